board_store: RTL and testbench



---
 rtl/game_pkg.sv | 18 +
 rtl/board_store.sv | 96 +++++++++
 tb/tb_board_store.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared playfield definitions: grid size, cell-coordinate widths and the
// row-clear sweep state encoding used by the game FSM, board store and renderer.
package game_pkg;
    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int XW   = 4;
    localparam int YW   = 5;

    typedef logic [XW-1:0] cell_x_t;
    typedef logic [YW-1:0] cell_y_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } sweep_state_t;
endpackage

// File: rtl/board_store.sv
// Playfield occupancy grid with collision read, lock write, whole-row video read
// and the post-lock row-clear sweep (scan bottom-up, shift rows down per full row).
module board_store #(
    parameter int COLS = game_pkg::COLS,
    parameter int ROWS = game_pkg::ROWS
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic [game_pkg::XW-1:0]  board_rx,
    input  logic [game_pkg::YW-1:0]  board_ry,
    output logic                     board_rdata,
    input  logic                     board_we,
    input  logic [game_pkg::XW-1:0]  board_wx,
    input  logic [game_pkg::YW-1:0]  board_wy,
    input  logic                     board_wdata,
    input  logic                     clear_start,
    output logic                     clear_busy,
    output logic                     clear_done,
    output logic [game_pkg::YW-1:0]  lines_cleared,
    input  logic [game_pkg::YW-1:0]  vga_ry,
    output logic [COLS-1:0]          vga_row
);
    import game_pkg::*;

    localparam cell_x_t COLS_X = XW'(COLS);
    localparam cell_y_t ROWS_Y = YW'(ROWS);
    localparam cell_y_t LAST_Y = YW'(ROWS - 1);

    logic [ROWS-1:0][COLS-1:0] grid_q;
    sweep_state_t              state_q;
    cell_y_t                   scan_q;
    cell_y_t                   shift_q;
    cell_y_t                   lines_q;
    logic                      done_q;

    logic rd_in_range, wr_in_range, scan_full;

    assign rd_in_range = (board_rx < COLS_X) && (board_ry < ROWS_Y);
    assign wr_in_range = (board_wx < COLS_X) && (board_wy < ROWS_Y);
    assign scan_full   = &grid_q[scan_q];

    // Off-board cells read as occupied so the FSM treats walls and floor as solid.
    assign board_rdata   = rd_in_range ? grid_q[board_ry][board_rx] : 1'b1;
    assign vga_row       = (vga_ry < ROWS_Y) ? grid_q[vga_ry] : '0;
    assign clear_busy    = (state_q != S_IDLE);
    assign clear_done    = done_q;
    assign lines_cleared = lines_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            grid_q  <= '0;
            state_q <= S_IDLE;
            scan_q  <= '0;
            shift_q <= '0;
            lines_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (board_we && wr_in_range)
                        grid_q[board_wy][board_wx] <= board_wdata;
                    if (clear_start) begin
                        state_q <= S_SCAN;
                        scan_q  <= LAST_Y;
                        lines_q <= '0;
                    end
                end
                S_SCAN: begin
                    if (scan_full) begin
                        state_q <= S_SHIFT;
                        shift_q <= scan_q;
                        lines_q <= lines_q + 5'd1;
                    end else if (scan_q == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        scan_q <= scan_q - 5'd1;
                    end
                end
                S_SHIFT: begin
                    // Rescan the same row afterwards: the row above has dropped into it.
                    if (shift_q != '0) begin
                        grid_q[shift_q] <= grid_q[shift_q - 5'd1];
                        shift_q         <= shift_q - 5'd1;
                    end else begin
                        grid_q[0] <= '0;
                        state_q   <= S_SCAN;
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_board_store.sv
// Self-checking bench for board_store: directed scenarios plus random boards
// compared against a row-removal reference model.
module tb_board_store;
    localparam int COLS = 10;
    localparam int ROWS = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      board_rx, board_wx;
    logic [4:0]      board_ry, board_wy, vga_ry, lines_cleared;
    logic            board_rdata, board_we, board_wdata;
    logic            clear_start, clear_busy, clear_done;
    logic [COLS-1:0] vga_row;

    int errors = 0;
    int checks = 0;

    typedef logic [COLS-1:0] row_t;
    row_t mdl [ROWS];

    board_store #(.COLS(COLS), .ROWS(ROWS)) dut (
        .CLOCK_50(clk), .reset(rst),
        .board_rx(board_rx), .board_ry(board_ry), .board_rdata(board_rdata),
        .board_we(board_we), .board_wx(board_wx), .board_wy(board_wy), .board_wdata(board_wdata),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .lines_cleared(lines_cleared), .vga_ry(vga_ry), .vga_row(vga_row)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
    endtask

    task automatic wr(input int x, input int y, input bit d);
        board_we = 1'b1; board_wx = 4'(x); board_wy = 5'(y); board_wdata = d;
        step();
        board_we = 1'b0;
    endtask

    task automatic clear_model();
        for (int y = 0; y < ROWS; y++) mdl[y] = '0;
    endtask

    task automatic load_model();
        do_reset();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                if (mdl[y][x]) wr(x, y, 1'b1);
    endtask

    // Reference: drop full rows, compact survivors to the bottom, pad with empty rows.
    // Also predicts the clear_done cycle: a full row originally at y is found at index
    // y + (full rows below it), costing 1 scan + (index+1) shift cycles.
    task automatic model_clear(output int nclr, output int done_cyc);
        row_t nb [ROWS];
        int k;
        k = ROWS - 1;
        nclr = 0;
        done_cyc = ROWS + 1;
        for (int y = ROWS - 1; y >= 0; y--) begin
            if (mdl[y] == {COLS{1'b1}}) begin
                done_cyc += 1 + (y + nclr + 1);
                nclr++;
            end else begin
                nb[k] = mdl[y];
                k--;
            end
        end
        for (int y = 0; y <= k; y++) nb[y] = '0;
        for (int y = 0; y < ROWS; y++) mdl[y] = nb[y];
    endtask

    task automatic sweep(output int cyc, output bit ok);
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        ok = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 3000; c++) begin
            cyc = c;
            if (clear_done) begin ok = 1'b1; break; end
            step();
        end
        step();
    endtask

    task automatic check_board(input string name);
        for (int y = 0; y < ROWS; y++) begin
            vga_ry = 5'(y);
            #1;
            checks++;
            if (vga_row !== mdl[y]) begin
                errors++;
                $display("FAIL %s row %0d: got %b want %b", name, y, vga_row, mdl[y]);
            end
        end
        step();
    endtask

    task automatic check_sweep(input string name, input bit ok, input int cyc,
                               input int want_cyc, input int want_lines);
        checks++;
        if (!ok || cyc != want_cyc) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d (seen=%0b) want %0d", name, cyc, ok, want_cyc);
        end
        checks++;
        if (lines_cleared !== 5'(want_lines)) begin
            errors++;
            $display("FAIL %s lines: got %0d want %0d", name, lines_cleared, want_lines);
        end
    endtask

    task automatic test_reset();
        do_reset();
        clear_model();
        checks++;
        if (clear_busy !== 1'b0 || clear_done !== 1'b0 || lines_cleared !== 5'd0) begin
            errors++;
            $display("FAIL reset_status: busy=%b done=%b lines=%0d want 0 0 0",
                     clear_busy, clear_done, lines_cleared);
        end
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                board_rx = 4'(x); board_ry = 5'(y);
                #0.1;
                checks++;
                if (board_rdata !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_cell (%0d,%0d): got %b want 0", x, y, board_rdata);
                end
            end
        step();
        board_rx = 4'd10; board_ry = 5'd0; #1;
        checks++;
        if (board_rdata !== 1'b1) begin
            errors++; $display("FAIL oob_x: got %b want 1", board_rdata);
        end
        board_rx = 4'd0; board_ry = 5'd20; #1;
        checks++;
        if (board_rdata !== 1'b1) begin
            errors++; $display("FAIL oob_y: got %b want 1", board_rdata);
        end
        vga_ry = 5'd25; #1;
        checks++;
        if (vga_row !== '0) begin
            errors++; $display("FAIL vga_oob: got %b want 0", vga_row);
        end
        step();
        check_board("reset_board");
    endtask

    task automatic test_write();
        int cyc; bit ok;
        do_reset();
        wr(3, 19, 1'b1);
        board_rx = 4'd3; board_ry = 5'd19; #1;
        checks++;
        if (board_rdata !== 1'b1) begin
            errors++; $display("FAIL write_read: got %b want 1", board_rdata);
        end
        wr(12, 2, 1'b1);   // out of range, must not alias anywhere
        wr(3, 19, 1'b0);
        clear_model();
        check_board("write_clear");
        // Write attempted mid-sweep is dropped.
        clear_start = 1'b1; step(); clear_start = 1'b0;
        step(); step();
        wr(4, 5, 1'b1);
        for (int c = 0; c < 40 && clear_busy; c++) step();
        step();
        board_rx = 4'd4; board_ry = 5'd5; #1;
        checks++;
        if (board_rdata !== 1'b0) begin
            errors++; $display("FAIL write_busy: got %b want 0", board_rdata);
        end
        step();
        check_board("write_busy_board");
    endtask

    task automatic test_clear_one();
        int n, dc, cyc; bit ok;
        clear_model();
        mdl[19] = '1; mdl[18][2] = 1'b1;
        load_model();
        model_clear(n, dc);
        sweep(cyc, ok);
        check_sweep("clear_one", ok, cyc, dc, 1);
        check_board("clear_one");
    endtask

    task automatic test_clear_two();
        int n, dc, cyc; bit ok;
        clear_model();
        mdl[19] = '1; mdl[18] = '1; mdl[17][5] = 1'b1;
        load_model();
        model_clear(n, dc);
        sweep(cyc, ok);
        check_sweep("clear_two", ok, cyc, dc, 2);
        check_board("clear_two");
    endtask

    task automatic test_timing();
        do_reset();
        clear_start = 1'b1; step(); clear_start = 1'b0;
        for (int c = 1; c <= 23; c++) begin
            clear_start = (c == 5);   // ignored while busy
            checks++;
            if (clear_busy !== (c <= 21) || clear_done !== (c == 21)) begin
                errors++;
                $display("FAIL timing cycle %0d: busy=%b done=%b want %b %b",
                         c, clear_busy, clear_done, (c <= 21), (c == 21));
            end
            step();
        end
        clear_start = 1'b0;
        checks++;
        if (lines_cleared !== 5'd0) begin
            errors++; $display("FAIL timing_lines: got %0d want 0", lines_cleared);
        end
    endtask

    task automatic test_full_board_and_row0();
        int n, dc, cyc; bit ok;
        for (int y = 0; y < ROWS; y++) mdl[y] = '1;
        load_model();
        model_clear(n, dc);
        sweep(cyc, ok);
        check_sweep("full_board", ok, cyc, dc, ROWS);
        check_board("full_board");
        clear_model();
        mdl[0] = '1; mdl[7][1] = 1'b1;
        load_model();
        model_clear(n, dc);
        sweep(cyc, ok);
        check_sweep("row0", ok, cyc, dc, 1);
        check_board("row0");
    endtask

    task automatic test_write_with_start();
        int n, dc, cyc; bit ok;
        clear_model();
        mdl[19] = 10'b1111111110; mdl[18] = 10'b0000110001;
        load_model();
        mdl[19][0] = 1'b1;
        model_clear(n, dc);
        board_we = 1'b1; board_wx = 4'd0; board_wy = 5'd19; board_wdata = 1'b1;
        sweep(cyc, ok);
        board_we = 1'b0;
        check_sweep("we_start", ok, cyc, dc, 1);
        check_board("we_start");
    endtask

    task automatic test_random();
        int n, dc, cyc; bit ok;
        for (int t = 0; t < 8; t++) begin
            for (int y = 0; y < ROWS; y++) begin
                if (y >= 6 && $urandom_range(0, 2) == 0) mdl[y] = '1;
                else if (y >= 6) mdl[y] = row_t'($urandom) & ~(row_t'(1) << $urandom_range(0, COLS - 1));
                else mdl[y] = '0;
            end
            load_model();
            model_clear(n, dc);
            sweep(cyc, ok);
            check_sweep($sformatf("rand%0d", t), ok, cyc, dc, n);
            check_board($sformatf("rand%0d", t));
        end
    endtask

    task automatic test_reset_mid();
        clear_model();
        mdl[19] = '1; mdl[3] = 10'b1010101010; mdl[12][9] = 1'b1;
        load_model();
        clear_start = 1'b1; step(); clear_start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        #1;
        checks++;
        if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_status: busy=%b done=%b want 0 0", clear_busy, clear_done);
        end
        clear_model();
        check_board("reset_mid_board");
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            checks++;
            if (clear_done !== 1'b0 || clear_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_after cycle %0d: busy=%b done=%b want 0 0",
                         c, clear_busy, clear_done);
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b0; board_rx = '0; board_ry = '0; board_we = 1'b0; board_wx = '0;
        board_wy = '0; board_wdata = 1'b0; clear_start = 1'b0; vga_ry = '0;
        test_reset();
        test_write();
        test_clear_one();
        test_clear_two();
        test_timing();
        test_full_board_and_row0();
        test_write_with_start();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
